// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add sequencer wrapped around one external
// full-adder cell. Operands are consumed LSB first, one bit per clock, and
// the result is collected back into a shift register.
// Optional build macro SERIAL_ADD_SUB_EN adds a 'sub' port that selects
// a-b (two's complement: invert b, carry-in of 1) instead of a+b.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_x,
  output logic             fa_y,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, nxt;
  logic [WIDTH-1:0] a_sh, b_sh, acc;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             accept, last, inv_b, init_c;

  // start is only honoured between operations; RUN ignores it entirely
  assign accept = start && (state == IDLE || state == DONE);
  // final bit of the operation is on the adder this cycle
  assign last   = (state == RUN) && (cnt == CW'(WIDTH-1));

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q;
  // subtract mode is frozen for the whole operation
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)      sub_q <= 1'b0;
    else if (accept) sub_q <= sub;
  assign inv_b  = sub_q;
  assign init_c = sub;
`else
  assign inv_b  = 1'b0;
  assign init_c = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;

  // next-state: DONE is a single cycle and may chain straight into RUN
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = RUN;
      RUN:     if (last)  nxt = DONE;
      DONE:    nxt = start ? RUN : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // outputs: adder inputs are only driven while an operation is in flight
  always_comb begin
    busy   = (state == RUN);
    done   = (state == DONE);
    fa_x   = 1'b0;
    fa_y   = 1'b0;
    fa_cin = 1'b0;
    if (state == RUN) begin
      fa_x   = a_sh[0];
      fa_y   = b_sh[0] ^ inv_b;
      fa_cin = carry_q;
    end
  end

  // datapath: latch on accept, shift one bit per RUN cycle, publish on last
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      a_sh    <= a;
      b_sh    <= b;
      acc     <= '0;
      carry_q <= init_c;
      cnt     <= '0;
    end else if (state == RUN) begin
      a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
      acc     <= {fa_s, acc[WIDTH-1:1]};
      carry_q <= fa_cout;
      cnt     <= cnt + 1'b1;
      if (last) begin
        sum  <= {fa_s, acc[WIDTH-1:1]};
        cout <= fa_cout;
      end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: behavioural full adder in the loop, expected
// results queued at issue time and popped by a monitor on each done pulse.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk, rst_n, start;
  logic [W-1:0] a, b, sum;
  logic         busy, done, cout, fa_x, fa_y, fa_cin, fa_s, fa_cout;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif

  int n_vec = 0;
  int n_bad = 0;
  logic [W:0] exp_q[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .fa_x(fa_x), .fa_y(fa_y), .fa_cin(fa_cin),
    .fa_s(fa_s), .fa_cout(fa_cout)
  );

  // behavioural full adder cell
  assign fa_s    = fa_x ^ fa_y ^ fa_cin;
  assign fa_cout = (fa_x & fa_y) | (fa_x & fa_cin) | (fa_y & fa_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {23'd0, cout, sum}, 32'hDEAD);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        chk("result_sum_cout", {23'd0, cout, sum}, {23'd0, e});
      end
    end
  end

  // bounded wait for done, then step out of the DONE cycle
  task automatic wait_done(input string name);
    int k = 0;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk(name, {31'd0, done}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] es, input logic ec);
    a = av; b = bv; start = 1'b1;
    exp_q.push_back({ec, es});
    @(posedge clk); #1;
    start = 1'b0;
    a = '0; b = '0;
    wait_done("op_done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] cins;
    rst_n = 1'b1; start = 1'b0; a = '0; b = '0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_sum",  {24'd0, sum}, 0);
    chk("rst_cout", {31'd0, cout}, 0);
    chk("rst_fa",   {29'd0, fa_x, fa_y, fa_cin}, 0);
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // 0x35+0x4A: 8 busy cycles, done right after edge 8
    a = 8'h35; b = 8'h4A; start = 1'b1;
    exp_q.push_back({1'b0, 8'h7F});
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk("lat_busy", {31'd0, busy}, 1);
      @(posedge clk); #1;
    end
    chk("lat_done", {31'd0, done}, 1);
    chk("lat_busy_low", {31'd0, busy}, 0);
    @(posedge clk); #1;
    chk("idle_fa_zero", {29'd0, fa_x, fa_y, fa_cin}, 0);

    // 0xFF+0x01: carry ripples through every bit
    a = 8'hFF; b = 8'h01; start = 1'b1;
    exp_q.push_back({1'b1, 8'h00});
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      cins[i] = fa_cin;
      @(posedge clk); #1;
    end
    chk("carry_seq", {24'd0, cins}, 32'h000000FE);
    chk("carry_done", {31'd0, done}, 1);
    @(posedge clk); #1;

    // start held high: RUN ignores it and its operands, DONE chains to RUN
    a = 8'h80; b = 8'h80; start = 1'b1;
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b0, 8'h03});
    @(posedge clk); #1;
    a = 8'hAA; b = 8'h55;
    for (int i = 1; i < W; i++) begin
      @(posedge clk); #1;
      chk("b2b_busy", {31'd0, busy}, 1);
    end
    @(posedge clk); #1;
    chk("b2b_done1", {31'd0, done}, 1);
    a = 8'h01; b = 8'h02;
    @(posedge clk); #1;
    chk("b2b_no_idle", {31'd0, busy}, 1);
    start = 1'b0; a = 8'hFF; b = 8'hFF;
    wait_done("b2b_done2");

    // reset in the 4th RUN cycle aborts with no done pulse and clears outputs
    a = 8'h12; b = 8'h34; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_sum",  {24'd0, sum}, 0);
    chk("abort_cout", {31'd0, cout}, 0);
    chk("abort_fa",   {29'd0, fa_x, fa_y, fa_cin}, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    start_op(8'h12, 8'h34, 8'h46, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b1;
    start_op(8'h10, 8'h01, 8'h0F, 1'b1);
    start_op(8'h01, 8'h02, 8'hFF, 1'b0);
    sub = 1'b0;
    start_op(8'h10, 8'h01, 8'h11, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #1 chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial addition sequencer that drives one external single-bit full adder, LSB first, one bit per clock. It latches two WIDTH-bit operands on a start pulse and presents one operand bit pair plus the stored carry to the full adder each cycle. It collects the sum bit and carry-out back into a result register. Sits directly upstream and downstream of the FullAdder cell in the Basys3 lab datapath, replacing a ripple chain with one adder cell and WIDTH clock cycles.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous, active-low reset
start  input  1  request new addition; sampled only in IDLE or DONE
a  input  WIDTH  operand A, sampled on accepted start
b  input  WIDTH  operand B, sampled on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse: result valid
sum  output  WIDTH  registered result, held until next completion
cout  output  1  registered final carry, held until next completion
fa_x  output  1  bit to full adder x input
fa_y  output  1  bit to full adder y input
fa_cin  output  1  carry to full adder Cin input
fa_s  input  1  full adder sum bit
fa_cout  input  1  full adder carry out

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, fa_x=fa_y=fa_cin=0, internal shift registers, carry flop and bit counter all 0.
- Reset asserted mid-RUN aborts the operation immediately. No done pulse is produced. sum and cout clear to 0.
- States: IDLE, RUN, DONE.
- IDLE to RUN when start=1. At that edge: a_sh<=a, b_sh<=b, carry_q<=0, cnt<=0, acc<=0.
- RUN, each cycle:
  - Combinational outputs: fa_x=a_sh[0], fa_y=b_sh[0], fa_cin=carry_q.
  - At the edge: acc<={fa_s, acc[WIDTH-1:1]}, carry_q<=fa_cout, a_sh and b_sh shift right by 1 with zero fill, cnt<=cnt+1.
- RUN to DONE on the edge where cnt==WIDTH-1, which is the WIDTH-th bit. On that same edge: sum<={fa_s, acc[WIDTH-1:1]} and cout<=fa_cout.
- DONE lasts exactly one cycle with done=1. Next state is RUN if start=1 (new operands latched as from IDLE), otherwise IDLE.
- Latency: start sampled at edge 0 gives done high in the cycle after edge WIDTH. Back-to-back operations occupy WIDTH+1 cycles each.
- start is ignored while in RUN. Operands and outputs are unaffected.
- busy=1 exactly in RUN.
- fa_x, fa_y and fa_cin are driven to 0 outside RUN.
- Arithmetic is unsigned modulo 2^WIDTH. cout is the carry out of bit WIDTH-1.
- a and b may change freely after the accepting edge.
- sum and cout are stable outside completion edges.
- The full adder path is purely combinational, with no extra pipeline stage assumed.

Optional Feature:
SERIAL_ADD_SUB_EN
- Defined:
  - Adds input port sub (1 bit), sampled together with a and b on an accepted start and held in a flop for the operation.
  - When sub=1: fa_y=~b_sh[0] and carry_q is initialised to 1, giving sum=a-b mod 2^WIDTH. cout=1 means no borrow (a>=b).
  - When sub=0: behaviour is identical to the undefined build.
- Undefined: no sub port; addition only; carry_q always initialised to 0.

Test Plan:
- The bench supplies a behavioural full adder (s=x^y^cin, cout=majority). WIDTH=8 throughout.
- a=0x35, b=0x4A, start pulsed at edge 0 -> busy high for 8 cycles; done high in the cycle after edge 8; sum=0x7F, cout=0.
- a=0xFF, b=0x01 -> sum=0x00, cout=1. Per-cycle fa_cin sequence 0,1,1,1,1,1,1,1 in bits 0..7.
- start held high continuously with a=0x80, b=0x80 then a=0x01, b=0x02 presented at the DONE cycle -> first result 0x00/cout=1. Second operation starts from DONE with no IDLE cycle and gives 0x03/cout=0. start pulses during RUN change nothing.
- rst_n low at cycle 4 of an 0x12+0x34 operation -> busy, done, sum, cout and fa_* go 0 asynchronously with no done pulse. A following 0x12+0x34 gives sum=0x46, cout=0.
- SERIAL_ADD_SUB_EN defined, sub=1:
  - a=0x10, b=0x01 -> sum=0x0F, cout=1.
  - a=0x01, b=0x02 -> sum=0xFF, cout=0.
  - sub=0, a=0x10, b=0x01 -> sum=0x11.
